// File: rtl/skid_buf_if.sv
// skid_buf_if: valid/ready handshake bundle for the skid buffer's upstream and downstream sides.
interface skid_buf_if #(parameter int DAT_W = 32);
  logic             s_valid;
  logic             s_ready;
  logic [DAT_W-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [DAT_W-1:0] m_data;
  logic [1:0]       occ;
  modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data, occ);
  modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data, occ);
endinterface

// File: rtl/skid_buf.sv
// skid_buf: registered valid/ready skid buffer, one main entry plus one skid entry.
module skid_buf #(parameter int DAT_W = 32) (
  input logic       clk,
  input logic       rst_n,
  skid_buf_if.slave bus
);
  // Encoding equals occupancy so occ comes straight off the state flops.
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
  state_t           state_q, state_d;
  logic [DAT_W-1:0] main_q, main_d, skid_q, skid_d;
  logic             m_valid_q, m_valid_d, s_ready_q, s_ready_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      m_valid_q <= m_valid_d;
      s_ready_q <= s_ready_d;
    end
  end
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (bus.s_valid) begin
        main_d  = bus.s_data;
        state_d = BUSY;
      end
      BUSY: begin
        if (bus.s_valid && bus.m_ready) main_d = bus.s_data;
        if (bus.s_valid && !bus.m_ready) begin
          skid_d  = bus.s_data;
          state_d = FULL;
        end
        if (!bus.s_valid && bus.m_ready) state_d = EMPTY;
      end
      FULL: if (bus.m_ready) begin
        main_d  = skid_q;
        state_d = BUSY;
      end
      default: state_d = EMPTY;
    endcase
  end
  // Handshake outputs are precomputed from the next state so they leave from flops.
  always_comb begin
    m_valid_d = state_d != EMPTY;
    s_ready_d = state_d != FULL;
  end
  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = main_q;
  assign bus.occ     = state_q;
endmodule

// File: doc/skid_buf.md
# skid_buf

- Registered valid/ready skid buffer, `DAT_W` wide, one entry deep plus one skid entry.
- Sits directly upstream of the `dff` data stage and feeds its `d` input from `m_data`.
- Adds backpressure to an otherwise free-running register path while sustaining one transfer per cycle.
- `s_ready`, `m_valid` and `m_data` all come straight from flops, which breaks both the forward and the backward timing path.

## Interface
- `DAT_W`, default 32: data width; matches the project-wide `DAT_W` define.
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `s_valid`, input, 1: upstream data valid.
- `s_ready`, output, 1: block can accept; registered.
- `s_data`, input, `DAT_W`: upstream data.
- `m_valid`, output, 1: output data valid; registered.
- `m_ready`, input, 1: downstream accepts.
- `m_data`, output, `DAT_W`: output data; registered.
- `occ`, output, 2: entries held (0, 1 or 2); registered.

## Operation
- Transfers:
  - Upstream transfer: `s_valid && s_ready` at a rising edge.
  - Downstream transfer: `m_valid && m_ready` at a rising edge.
- Storage:
  - Main register `main_q` drives `m_data`.
  - Skid register `skid_q` holds one word captured while downstream stalls.
- State machine, three states:
  - EMPTY: `occ`=0, `m_valid`=0, `s_ready`=1.
  - BUSY: `occ`=1, `m_valid`=1, `s_ready`=1.
  - FULL: `occ`=2, `m_valid`=1, `s_ready`=0.
- Transitions from EMPTY:
  - `s_valid`: `main_q`<=`s_data`, go to BUSY.
  - otherwise: stay in EMPTY.
- Transitions from BUSY:
  - `s_valid && m_ready`: `main_q`<=`s_data`, stay in BUSY (simultaneous in/out).
  - `s_valid && !m_ready`: `skid_q`<=`s_data`, go to FULL.
  - `!s_valid && m_ready`: go to EMPTY.
  - neither: hold.
- Transitions from FULL:
  - `m_ready`: `main_q`<=`skid_q`, go to BUSY.
  - otherwise: hold. `s_valid` is ignored because `s_ready`=0.
- Ordering: output order always equals input order. No word is dropped or duplicated.
- Data path carries data only; no arithmetic. `s_data` is captured at full `DAT_W`, with no truncation.
- `m_data` is 0 before the first load. It holds its last value after draining to EMPTY.
- `skid_q` contents are don't-care outside FULL.

## Timing
- Reset (`rst_n` low, asynchronous, immediate):
  - State goes to EMPTY.
  - `m_valid`=0, `s_ready`=1, `occ`=0, `m_data`=0, `skid_q`=0.
- Reset mid-operation discards both entries. The first edge after release behaves as EMPTY.
- Latency: a word accepted at edge N appears on `m_data` with `m_valid`=1 after edge N, so it is presented in cycle N+1.
- Throughput: one word per cycle while `m_ready`=1 continuously.
- `s_ready` falls the cycle after the skid fills. It rises the cycle after a downstream transfer out of FULL.
- `m_valid`/`m_data` stability: while `m_valid && !m_ready`, `m_valid` and `m_data` must stay constant.
- Upstream obligation: upstream may change or drop `s_valid` at any time. The block never relies on upstream holding `s_data`.
- `m_valid` never depends combinationally on `m_ready`. `s_ready` never depends combinationally on `s_valid`.
- `occ` always equals (upstream transfers − downstream transfers) since reset.

## Test plan
- Reset check: hold `rst_n`=0 for 3 cycles, then release.
  - During and after reset: `m_valid`=0, `s_ready`=1, `occ`=0, `m_data`=0.
- Single word: drive `s_data`=0x00000001 with `s_valid` for 1 cycle, `m_ready`=1.
  - `m_valid`=1 with `m_data`=0x00000001 for exactly one cycle, then EMPTY.
- Streaming: drive 0x00 to 0x63 back-to-back with `m_ready`=1 throughout.
  - 100 outputs in order on consecutive cycles, first one cycle after first input.
  - `s_ready` stays 1 and `occ`≤1 throughout.
- Stall fill: `m_ready`=0, send 0xA and 0xB.
  - `occ`=2, `s_ready`=0, `m_data`=0xA held steady.
  - Drive 0xC for 3 cycles: not accepted.
  - Raise `m_ready`: outputs 0xA, 0xB, then 0xC, in that order.
- Random backpressure: 10 000 cycles of random `s_valid`/`m_ready`.
  - Scoreboard shows exact in-order match.
  - `occ` matches the transfer count delta.
  - `m_data` is stable during every stall.
- Reset mid-operation: in FULL holding 0x5 and 0x6, pulse `rst_n` low between edges.
  - `m_valid` drops immediately.
  - After release, 0x5 and 0x6 never appear.
  - A new word 0x7 passes with 1-cycle latency.
